// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-port definitions, also used by the regfile and the hazard unit.
package wb_port_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        S_PIPE  = 1'b0,
        S_STEAL = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_starve_cnt.sv
// Saturating count of cycles a pending MDU result has lost the write port.
module wb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear on handshake, otherwise count losses up to STARVE_MAX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_inc && (r_cnt != CNT_W'(STARVE_MAX))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // One more loss from here exhausts the MDU's patience.
    assign o_at_limit = (r_cnt >= CNT_W'(STARVE_MAX - 1));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the MDU
// result is guaranteed a slot by stealing one cycle after STARVE_MAX losses.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pipe_wren,
    input  logic [REG_ADDR_W-1:0] i_pipe_rd,
    input  logic [XLEN-1:0]       i_pipe_data,
    input  logic                  i_mdu_valid,
    input  logic [REG_ADDR_W-1:0] i_mdu_rd,
    input  logic [XLEN-1:0]       i_mdu_data,
    output logic                  o_mdu_ready,
    output logic                  o_stall,
    output logic                  o_rd_wren,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_grant_mdu
);

    wb_arb_state_e         r_state;
    wb_arb_state_e         w_state_nxt;
    logic                  w_grant_pipe;
    logic                  w_grant_mdu;
    logic                  w_stall;
    logic                  w_mdu_lose;
    logic                  w_at_limit;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;

    wb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_grant_mdu),
        .i_inc      (w_mdu_lose),
        .o_at_limit (w_at_limit)
    );

    // Arbiter state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_PIPE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection and next state; reset level gates every grant off.
    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_mdu  = 1'b0;
        w_stall      = 1'b0;
        w_state_nxt  = S_PIPE;
        if (!i_rst_n) begin
            w_grant_pipe = 1'b0;
        end else if ((r_state == S_STEAL) && i_mdu_valid) begin
            w_grant_mdu = 1'b1;
            w_stall     = i_pipe_wren;
        end else if (i_pipe_wren) begin
            w_grant_pipe = 1'b1;
        end else if (i_mdu_valid) begin
            w_grant_mdu = 1'b1;
        end else begin
            w_grant_pipe = 1'b0;
        end

        w_mdu_lose = i_rst_n & i_mdu_valid & ~w_grant_mdu;

        case (r_state)
            S_PIPE:  w_state_nxt = (w_mdu_lose && w_at_limit) ? S_STEAL : S_PIPE;
            S_STEAL: w_state_nxt = S_PIPE;
            default: w_state_nxt = S_PIPE;
        endcase
    end

    // Route the granted requester onto the write port, zero when idle.
    always_comb begin
        w_addr = {REG_ADDR_W{1'b0}};
        w_data = {XLEN{1'b0}};
        if (w_grant_mdu) begin
            w_addr = i_mdu_rd;
            w_data = i_mdu_data;
        end else if (w_grant_pipe) begin
            w_addr = i_pipe_rd;
            w_data = i_pipe_data;
        end else begin
            w_addr = {REG_ADDR_W{1'b0}};
            w_data = {XLEN{1'b0}};
        end
    end

    // x0 is never written, but an MDU handshake to x0 still completes.
    assign o_rd_wren   = (w_grant_mdu | w_grant_pipe) & (w_addr != {REG_ADDR_W{1'b0}});
    assign o_rd_addr   = w_addr;
    assign o_rd_data   = w_data;
    assign o_mdu_ready = w_grant_mdu;
    assign o_grant_mdu = w_grant_mdu;
    assign o_stall     = w_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter, STARVE_MAX = 4 and 1.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wren;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid [2];
    logic [4:0]  mdu_rd    [2];
    logic [31:0] mdu_data  [2];

    logic        d_ready [2];
    logic        d_stall [2];
    logic        d_wren  [2];
    logic [4:0]  d_addr  [2];
    logic [31:0] d_data  [2];
    logic        d_gmdu  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whether this cycle is a steal slot, and losses so far.
    bit m_steal [2];
    int m_loss  [2];
    bit m_acc   [2];
    bit e_gm    [2];

    logic        last_ready [2];
    logic        last_stall [2];
    logic        last_wren  [2];
    logic [4:0]  last_addr  [2];
    logic [31:0] last_data  [2];

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_MAX(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_wren(pipe_wren), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
        .i_mdu_valid(mdu_valid[0]), .i_mdu_rd(mdu_rd[0]), .i_mdu_data(mdu_data[0]),
        .o_mdu_ready(d_ready[0]), .o_stall(d_stall[0]), .o_rd_wren(d_wren[0]),
        .o_rd_addr(d_addr[0]), .o_rd_data(d_data[0]), .o_grant_mdu(d_gmdu[0])
    );

    wb_port_arbiter #(.STARVE_MAX(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_wren(pipe_wren), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
        .i_mdu_valid(mdu_valid[1]), .i_mdu_rd(mdu_rd[1]), .i_mdu_data(mdu_data[1]),
        .o_mdu_ready(d_ready[1]), .o_stall(d_stall[1]), .o_rd_wren(d_wren[1]),
        .o_rd_addr(d_addr[1]), .o_rd_data(d_data[1]), .o_grant_mdu(d_gmdu[1])
    );

    function automatic int sm_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_steal[i] = 1'b0;
            m_loss[i]  = 0;
            m_acc[i]   = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_i%0d_wren", tag, i),  {31'd0, d_wren[i]},  32'd0);
            check_val($sformatf("%s_i%0d_ready", tag, i), {31'd0, d_ready[i]}, 32'd0);
            check_val($sformatf("%s_i%0d_stall", tag, i), {31'd0, d_stall[i]}, 32'd0);
            check_val($sformatf("%s_i%0d_gmdu", tag, i),  {31'd0, d_gmdu[i]},  32'd0);
            check_val($sformatf("%s_i%0d_addr", tag, i),  {27'd0, d_addr[i]},  32'd0);
            check_val($sformatf("%s_i%0d_data", tag, i),  d_data[i],           32'd0);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit          sa;
            bit          gm;
            bit          gp;
            bit          ew;
            logic [4:0]  ea;
            logic [31:0] ed;
            sa = rst_n && m_steal[i] && mdu_valid[i];
            gm = rst_n && (sa || (!pipe_wren && mdu_valid[i]));
            gp = rst_n && !sa && pipe_wren;
            ea = gm ? mdu_rd[i]   : (gp ? pipe_rd   : 5'd0);
            ed = gm ? mdu_data[i] : (gp ? pipe_data : 32'd0);
            ew = (gm || gp) && (ea != 5'd0);
            check_val($sformatf("i%0d_wren", i),  {31'd0, d_wren[i]},  {31'd0, ew});
            check_val($sformatf("i%0d_addr", i),  {27'd0, d_addr[i]},  {27'd0, ea});
            check_val($sformatf("i%0d_data", i),  d_data[i],           ed);
            check_val($sformatf("i%0d_ready", i), {31'd0, d_ready[i]}, {31'd0, gm});
            check_val($sformatf("i%0d_gmdu", i),  {31'd0, d_gmdu[i]},  {31'd0, gm});
            check_val($sformatf("i%0d_stall", i), {31'd0, d_stall[i]}, {31'd0, (sa && pipe_wren)});
            e_gm[i]       = gm;
            last_ready[i] = d_ready[i];
            last_stall[i] = d_stall[i];
            last_wren[i]  = d_wren[i];
            last_addr[i]  = d_addr[i];
            last_data[i]  = d_data[i];
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit lost;
                bit nxt;
                lost = mdu_valid[i] && !e_gm[i];
                nxt  = !m_steal[i] && lost && (m_loss[i] == sm_of(i) - 1);
                if (e_gm[i])
                    m_loss[i] = 0;
                else if (lost && m_loss[i] < sm_of(i))
                    m_loss[i] = m_loss[i] + 1;
                m_steal[i] = nxt;
                m_acc[i]   = e_gm[i];
            end
        end
        #1;
    endtask

    task automatic set_mdu(input bit v, input logic [4:0] rd, input logic [31:0] data);
        for (int i = 0; i < 2; i++) begin
            mdu_valid[i] = v;
            mdu_rd[i]    = rd;
            mdu_data[i]  = data;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pipe_wren = 1'b0;
        pipe_rd   = 5'd0;
        pipe_data = 32'd0;
        set_mdu(1'b0, 5'd0, 32'd0);
        model_reset();
        run_cycle();
        run_cycle();
        rst_n = 1'b1;
    endtask

    // Count cycles the given instance loses before its MDU result is taken.
    task automatic wait_mdu_grant(input int inst, output int lost, output bit stalled);
        lost    = 0;
        stalled = 1'b0;
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            if (last_ready[inst]) begin
                stalled = last_stall[inst];
                return;
            end
            lost++;
        end
        check_val("grant_timeout", 32'd0, 32'd1);
    endtask

    int  lost;
    bit  stalled;
    int  grant_cyc [$];
    int  n_stall;

    initial begin
        rst_n     = 1'b0;
        pipe_wren = 1'b0;
        pipe_rd   = 5'd0;
        pipe_data = 32'd0;
        set_mdu(1'b0, 5'd0, 32'd0);
        model_reset();
        #2;
        check_all_zero("rst");
        do_reset();

        // MDU result with an idle pipe goes straight through.
        set_mdu(1'b1, 5'd5, 32'hDEADBEEF);
        run_cycle();
        check_val("idle_data",  last_data[0], 32'hDEADBEEF);
        check_val("idle_ready", {31'd0, last_ready[0]}, 32'd1);
        set_mdu(1'b0, 5'd0, 32'd0);
        run_cycle();

        // Starvation window under continuous pipe writes to x3.
        do_reset();
        pipe_wren = 1'b1;
        pipe_rd   = 5'd3;
        pipe_data = 32'h0000_0333;
        set_mdu(1'b1, 5'd7, 32'h7777_0007);
        wait_mdu_grant(0, lost, stalled);
        check_val("starve_lost",  lost, 32'd4);
        check_val("starve_stall", {31'd0, stalled}, 32'd1);
        set_mdu(1'b0, 5'd0, 32'd0);
        run_cycle();
        check_val("held_pipe_addr", {27'd0, last_addr[0]}, 32'd3);
        check_val("held_pipe_wren", {31'd0, last_wren[0]}, 32'd1);

        // Smallest window: steal directly after the first loss.
        do_reset();
        pipe_wren = 1'b1;
        set_mdu(1'b1, 5'd9, 32'h0000_0909);
        wait_mdu_grant(1, lost, stalled);
        check_val("sm1_lost",  lost, 32'd1);
        check_val("sm1_stall", {31'd0, stalled}, 32'd1);

        // Write to x0 is suppressed but accepted; the window then restarts.
        do_reset();
        set_mdu(1'b1, 5'd0, 32'h1234_5678);
        run_cycle();
        check_val("x0_wren",  {31'd0, last_wren[0]},  32'd0);
        check_val("x0_ready", {31'd0, last_ready[0]}, 32'd1);
        pipe_wren = 1'b1;
        pipe_rd   = 5'd4;
        set_mdu(1'b1, 5'd8, 32'h0000_0808);
        wait_mdu_grant(0, lost, stalled);
        check_val("x0_fresh_lost", lost, 32'd4);

        // Valid dropped in the steal cycle: pipe keeps the port, no stall.
        do_reset();
        pipe_wren = 1'b1;
        pipe_rd   = 5'd3;
        set_mdu(1'b1, 5'd7, 32'h0000_0707);
        repeat (4) run_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        run_cycle();
        check_val("drop_stall", {31'd0, last_stall[0]}, 32'd0);
        check_val("drop_addr",  {27'd0, last_addr[0]},  32'd3);
        set_mdu(1'b1, 5'd7, 32'h0000_0707);
        run_cycle();
        check_val("drop_back_pipe", {31'd0, last_ready[0]}, 32'd0);

        // Asynchronous reset in the steal cycle.
        do_reset();
        pipe_wren = 1'b1;
        pipe_rd   = 5'd3;
        set_mdu(1'b1, 5'd7, 32'h0000_0707);
        repeat (4) run_cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midsteal_rst");
        run_cycle();
        rst_n = 1'b1;
        wait_mdu_grant(0, lost, stalled);
        check_val("post_rst_lost",  lost, 32'd4);
        check_val("post_rst_stall", {31'd0, stalled}, 32'd1);

        // Back-to-back MDU results under continuous pipe traffic.
        do_reset();
        pipe_wren = 1'b1;
        set_mdu(1'b1, 5'd10, 32'hA000_0001);
        grant_cyc.delete();
        n_stall = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            if (last_ready[0]) begin
                grant_cyc.push_back(c);
                if (last_stall[0]) n_stall++;
                mdu_data[0] = mdu_data[0] + 32'd1;
            end
        end
        check_val("b2b_count", grant_cyc.size(), 32'd2);
        if (grant_cyc.size() == 2)
            check_val("b2b_gap", grant_cyc[1] - grant_cyc[0], 32'd5);
        check_val("b2b_stalls", n_stall, 32'd2);

        // Randomized traffic against the model; MDU holds until accepted.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            pipe_wren = ($urandom_range(0, 9) < 7);
            pipe_rd   = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            for (int i = 0; i < 2; i++) begin
                if (!mdu_valid[i] || m_acc[i]) begin
                    mdu_valid[i] = ($urandom_range(0, 1) == 1);
                    mdu_rd[i]    = 5'($urandom_range(0, 31));
                    mdu_data[i]  = $urandom;
                end
            end
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage (the value already chosen by the writeback select mux) and the multi-cycle multiply/divide unit (MDU) result. The pipeline has priority by default. A starvation counter and a two-state FSM guarantee the MDU a slot by freezing the pipeline for exactly one cycle. The block sits between the WB stage and the regfile write port and drives the global writeback stall.

## Interface
Parameters:
- STARVE_MAX, default 4: number of consecutive cycles a valid MDU result may lose arbitration before a steal is forced; legal range 1..15.

Ports (single clock; reset is asynchronous, active-low):
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pipe_wren  in  1  WB-stage instruction writes a register.
- i_pipe_rd  in  5  WB-stage destination register.
- i_pipe_data  in  32  WB-stage write data, from the writeback select mux.
- i_mdu_valid  in  1  MDU result available; held until accepted.
- i_mdu_rd  in  5  MDU destination register.
- i_mdu_data  in  32  MDU result.
- o_mdu_ready  out  1  MDU result accepted this cycle (valid & ready = handshake).
- o_stall  out  1  freezes IF..WB for this cycle; WB inputs must repeat next cycle.
- o_rd_wren  out  1  regfile write enable.
- o_rd_addr  out  5  regfile write address.
- o_rd_data  out  32  regfile write data.
- o_grant_mdu  out  1  port owned by MDU this cycle (debug/trace).

## Operation
- FSM states: S_PIPE (reset state) and S_STEAL.
- S_PIPE grant: if i_pipe_wren, grant the pipe. Otherwise, if i_mdu_valid, grant the MDU. Otherwise there is no write.
- S_STEAL grant: if i_mdu_valid, grant the MDU and set o_stall = 1 when i_pipe_wren. If i_mdu_valid is unexpectedly low, behave as S_PIPE with no stall.
- o_stall is asserted only in S_STEAL with i_mdu_valid & i_pipe_wren; it is never asserted in S_PIPE.
- wait_cnt (width $clog2(STARVE_MAX+1)):
  - Cleared on reset and on any MDU handshake.
  - Increments each cycle i_mdu_valid & !o_mdu_ready.
  - Saturates at STARVE_MAX.
- Transitions:
  - S_PIPE -> S_STEAL when the MDU loses this cycle and wait_cnt == STARVE_MAX-1.
  - S_STEAL -> S_PIPE unconditionally after one cycle.
- Write to x0: when the granted rd == 0, o_rd_wren = 0, but the handshake still completes (o_mdu_ready = 1 if the MDU was granted).
- Data path: o_rd_addr and o_rd_data come from the granted requester. When nothing is granted they are 0.
- WAW ordering between the MDU and pipe to the same rd is guaranteed by the upstream scoreboard; this block does not check it.

## Timing
- Grant, o_rd_*, o_mdu_ready and o_stall are combinational from the inputs and registered state, with zero-cycle latency to the regfile.
- The regfile commits on the next rising edge.
- If the MDU becomes valid in cycle n while the pipe writes every cycle, it loses cycles n..n+STARVE_MAX-1 and is granted in cycle n+STARVE_MAX with o_stall = 1. The stalled pipe write commits in cycle n+STARVE_MAX+1.
- With STARVE_MAX = 1, the steal happens in the cycle after the first loss.
- Reset (async assert):
  - State forced to S_PIPE and wait_cnt to 0.
  - While i_rst_n is low, o_rd_wren, o_mdu_ready, o_stall and o_grant_mdu are forced to 0; o_rd_addr and o_rd_data are 0.
  - Reset asserted during S_STEAL aborts the steal; the MDU result is not accepted.
- Back-to-back MDU results: the counter restarts from 0 after each handshake, so each result gets its own starvation window.

## Structure
- A shared package holds typedef enum logic [0:0] {S_PIPE, S_STEAL} wb_arb_state_e, plus XLEN = 32 and REG_ADDR_W = 5, reused by the regfile and hazard unit.
- One natural sub-module, wb_starve_cnt: a saturating counter with clear/increment/at_limit outputs, parameterised by STARVE_MAX.
- The grant mux and FSM stay in the top.

## Test plan
- Idle pipe with an MDU result: i_pipe_wren = 0, MDU valid with rd = 5 and data 0xDEADBEEF.
  - Same cycle: o_rd_wren = 1, addr 5, data 0xDEADBEEF, o_mdu_ready = 1, o_stall = 0.
- Starvation steal: STARVE_MAX = 4, pipe writes every cycle (rd = 3), MDU valid from cycle 10 (rd = 7).
  - Cycles 10–13: pipe granted.
  - Cycle 14: MDU granted, o_stall = 1.
  - Cycle 15: held pipe write to x3 commits.
- x0 suppression: MDU with rd = 0 and the pipe idle.
  - o_rd_wren = 0, o_mdu_ready = 1, wait_cnt returns to 0.
- Valid dropped during S_STEAL: force i_mdu_valid low in the steal cycle.
  - o_stall = 0, pipe granted, FSM back to S_PIPE next cycle.
- Async reset mid-steal: assert i_rst_n low in the steal cycle.
  - All outputs are 0 immediately and no handshake occurs.
  - After release, state is S_PIPE and a fresh 4-cycle starvation window applies.
- Back-to-back MDU results under continuous pipe traffic: both are accepted, exactly STARVE_MAX+1 cycles apart, with one stall cycle each.
